// File: rtl/direction_normalize_pkg.sv
// Shared types for the ray-direction normalisation stage: fixed-point
// format, the input/output packet structs and the control FSM states.
package direction_normalize_pkg;

   localparam int WIDTH  = 16;
   localparam int Q_BITS = 8;

   typedef struct packed {
      logic signed [WIDTH-1:0] x;
      logic signed [WIDTH-1:0] y;
      logic signed [WIDTH-1:0] z;
   } RayDirection;

   typedef struct packed {
      logic signed [WIDTH-1:0] x;
      logic signed [WIDTH-1:0] y;
      logic signed [WIDTH-1:0] z;
      logic signed [WIDTH-1:0] len;
   } RayDirection_len;

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      DONE
   } norm_state_t;

endpackage

// File: rtl/direction_normalize_fifo.sv
// rdlen_fifo: small synchronous FIFO of RayDirection_len packets.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the packet is dropped and the sticky overflow flag is set.
module rdlen_fifo
   import direction_normalize_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  RayDirection_len din,
   output RayDirection_len dout,
   output logic            full,
   output logic            empty,
   output logic            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   RayDirection_len mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // pointer bookkeeping and sticky drop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !do_push) overflow <= 1'b1;
      end
   end

   // packet storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/direction_normalize.sv
// direction_normalize: divides each component of {x, y, z} by len using one
// shared restoring-division sequencer and three quotient datapaths.
// Build option: define RDNORM_ROUND_EN to compute one extra quotient bit and
// round half up (result clamped to 1.0); otherwise results truncate.
module direction_normalize
   import direction_normalize_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            valid_in,
   input  RayDirection_len RDLEN_in,
   output RayDirection     RD_out,
   output logic            valid_out,
   output logic            div_zero_out,
   output logic            overflow_out
);

`ifdef RDNORM_ROUND_EN
   localparam int K = Q_BITS + 1;
`else
   localparam int K = Q_BITS;
`endif
   localparam int CW = $clog2(K + 1);
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-Q_BITS-1){1'b0}}, 1'b1, {Q_BITS{1'b0}}};

   // Quotient bits to result magnitude; with the extra bit, round half up and clamp.
   function automatic logic [WIDTH-1:0] quo_to_mag(input logic [K-1:0] q);
      logic [WIDTH-1:0] m;
`ifdef RDNORM_ROUND_EN
      m = WIDTH'(q[K-1:1]) + WIDTH'(q[0]);
      if (m > ONE) m = ONE;
`else
      m = WIDTH'(q);
`endif
      return m;
   endfunction

   // Restore the component sign on an unsigned magnitude.
   function automatic logic signed [WIDTH-1:0] apply_sign(input logic neg,
                                                          input logic [WIDTH-1:0] mag);
      return neg ? -$signed(mag) : $signed(mag);
   endfunction

   norm_state_t             state;
   logic [CW-1:0]           cnt;
   logic [WIDTH-1:0]        len_u;
   logic                    len_zero;
   logic                    load;
   logic                    step;
   RayDirection_len         head;
   logic                    fifo_empty;
   // drops are decided inside the FIFO, so the top never needs its full flag
   logic                    fifo_full_unused;
   logic signed [WIDTH-1:0] comp_in  [3];
   logic signed [WIDTH-1:0] comp_res [3];

   rdlen_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (valid_in),
      .pop      (load),
      .din      (RDLEN_in),
      .dout     (head),
      .full     (fifo_full_unused),
      .empty    (fifo_empty),
      .overflow (overflow_out)
   );

   assign load = (state == IDLE) && !fifo_empty;
   assign step = (state == DIVIDE);

   assign comp_in[0] = head.x;
   assign comp_in[1] = head.y;
   assign comp_in[2] = head.z;

   // divisor captured at pop time; a non-positive length forces zero results
   always_ff @(posedge clk) begin
      if (load) begin
         len_u    <= $unsigned(head.len);
         len_zero <= head.len[WIDTH-1] || (head.len == '0);
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_comp
      logic [WIDTH-1:0] rem;
      logic [WIDTH:0]   rem_sh;
      logic [K-1:0]     quo;
      logic [WIDTH-1:0] mag_in;
      logic             neg;
      logic             sat;

      // most negative input maps to 2^(WIDTH-1), still representable unsigned
      assign mag_in = comp_in[i][WIDTH-1] ? $unsigned(-comp_in[i]) : $unsigned(comp_in[i]);
      assign rem_sh = {rem, 1'b0};

      // load operands at pop, then one restoring-division bit per DIVIDE edge
      always_ff @(posedge clk) begin
         if (load) begin
            neg <= comp_in[i][WIDTH-1];
            sat <= (mag_in >= $unsigned(head.len));
            rem <= mag_in;
            quo <= '0;
         end else if (step) begin
            if (rem_sh >= {1'b0, len_u}) begin
               rem <= rem_sh[WIDTH-1:0] - len_u;
               quo <= {quo[K-2:0], 1'b1};
            end else begin
               rem <= rem_sh[WIDTH-1:0];
               quo <= {quo[K-2:0], 1'b0};
            end
         end
      end

      assign comp_res[i] = len_zero ? '0 : apply_sign(neg, sat ? ONE : quo_to_mag(quo));
   end

   // sequencer: pop/load in IDLE, K divide edges, one output cycle in DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         valid_out    <= 1'b0;
         div_zero_out <= 1'b0;
         RD_out       <= '0;
      end else begin
         valid_out    <= 1'b0;
         div_zero_out <= 1'b0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cnt   <= CW'(K - 1);
                  state <= DIVIDE;
               end
            end
            DIVIDE: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CW'(1);
            end
            DONE: begin
               RD_out.x     <= comp_res[0];
               RD_out.y     <= comp_res[1];
               RD_out.z     <= comp_res[2];
               valid_out    <= 1'b1;
               div_zero_out <= len_zero;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_direction_normalize.sv
// Bench for direction_normalize: an arithmetic reference (exact division on
// integers, packet timing from acceptance times) compared every cycle,
// plus directed vectors with literal expectations.
module tb_direction_normalize;
   import direction_normalize_pkg::*;

`ifdef RDNORM_ROUND_EN
   localparam int K = Q_BITS + 1;
`else
   localparam int K = Q_BITS;
`endif
   localparam int LAT   = K + 2;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            valid_in = 1'b0;
   RayDirection_len RDLEN_in = '0;
   RayDirection     RD_out;
   logic            valid_out;
   logic            div_zero_out;
   logic            overflow_out;

   direction_normalize #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .RDLEN_in     (RDLEN_in),
      .RD_out       (RD_out),
      .valid_out    (valid_out),
      .div_zero_out (div_zero_out),
      .overflow_out (overflow_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 0;
   int dut_pulses = 0;
   int model_accepts = 0;

   typedef struct {
      int               push_e;
      int               pop_e;
      int               emerge;
      logic [WIDTH-1:0] x, y, z;
      logic             dz;
   } pkt_t;

   pkt_t        pq[$];
   int          e_prev = -1000;
   logic        exp_valid = 1'b0;
   logic        exp_dz = 1'b0;
   logic        exp_ovf = 1'b0;
   logic [47:0] exp_rd = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // c / len in Q-format from plain integer arithmetic
   function automatic logic [WIDTH-1:0] ref_comp(input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] len);
      longint sc, sl, mag, q;
      sc = longint'($signed(c));
      sl = longint'($signed(len));
      if (sl <= 0) return '0;
      mag = (sc < 0) ? -sc : sc;
`ifdef RDNORM_ROUND_EN
      q = (mag << (Q_BITS + 1)) / sl;
      q = (q + 1) / 2;
`else
      q = (mag << Q_BITS) / sl;
`endif
      if (q > (longint'(1) << Q_BITS)) q = longint'(1) << Q_BITS;
      if (sc < 0) q = -q;
      return q[WIDTH-1:0];
   endfunction

   // decide acceptance at edge n and schedule the packet's output edge
   task automatic model_accept(input int n);
      int   occ;
      bit   popnow;
      pkt_t p;
      occ = 0;
      popnow = 0;
      foreach (pq[i]) begin
         if (pq[i].push_e < n && pq[i].pop_e >= n) occ++;
         if (pq[i].pop_e == n) popnow = 1;
      end
      if (occ >= DEPTH && !popnow) begin
         exp_ovf = 1'b1;
      end else begin
         p.push_e = n;
         p.emerge = ((n > e_prev) ? n : e_prev) + LAT;
         p.pop_e  = p.emerge - (K + 1);
         p.x  = ref_comp(RDLEN_in.x, RDLEN_in.len);
         p.y  = ref_comp(RDLEN_in.y, RDLEN_in.len);
         p.z  = ref_comp(RDLEN_in.z, RDLEN_in.len);
         p.dz = ($signed(RDLEN_in.len) <= 0);
         e_prev = p.emerge;
         pq.push_back(p);
         model_accepts++;
      end
   endtask

   // reference model, advanced on every rising edge
   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         pq.delete();
         e_prev    = -1000;
         exp_valid = 1'b0;
         exp_dz    = 1'b0;
         exp_ovf   = 1'b0;
         exp_rd    = '0;
      end else begin
         exp_valid = 1'b0;
         exp_dz    = 1'b0;
         if (pq.size() > 0 && pq[0].emerge == cyc) begin
            exp_valid = 1'b1;
            exp_dz    = pq[0].dz;
            exp_rd    = {pq[0].x, pq[0].y, pq[0].z};
            pq.delete(0);
         end
         if (valid_in) model_accept(cyc);
      end
   end

   // compare DUT against the model between edges
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         if (valid_out === 1'b1) dut_pulses++;
         check("valid_out", 64'(valid_out), 64'(exp_valid));
         check("RD_out", 64'({RD_out.x, RD_out.y, RD_out.z}), 64'(exp_rd));
         check("div_zero_out", 64'(div_zero_out), 64'(exp_dz));
         check("overflow_out", 64'(overflow_out), 64'(exp_ovf));
      end
   end

   task automatic drive(input logic [WIDTH-1:0] x, y, z, len);
      RDLEN_in.x   = x;
      RDLEN_in.y   = y;
      RDLEN_in.z   = z;
      RDLEN_in.len = len;
      valid_in     = 1'b1;
   endtask

   task automatic directed(input string name, input logic [WIDTH-1:0] x, y, z, len,
                           input logic [47:0] exp, input logic exp_z);
      int t0;
      bit seen;
      @(negedge clk);
      drive(x, y, z, len);
      t0 = cyc + 1;
      @(negedge clk);
      valid_in = 1'b0;
      seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         if (valid_out === 1'b1) seen = 1;
         else @(negedge clk);
      end
      check({name, "_seen"}, 64'(seen), 64'(1));
      if (seen) begin
         check({name, "_latency"}, 64'(cyc - t0), 64'(LAT));
         check({name, "_rd"}, 64'({RD_out.x, RD_out.y, RD_out.z}), 64'(exp));
         check({name, "_dz"}, 64'(div_zero_out), 64'(exp_z));
      end
      @(negedge clk);
   endtask

   function automatic logic [WIDTH-1:0] rnd_val();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 3))
         0: v = WIDTH'($urandom);
         1: v = WIDTH'($urandom_range(0, 1024));
         2: v = -WIDTH'($urandom_range(0, 1024));
         default: begin
            case ($urandom_range(0, 3))
               0: v = 16'h8000;
               1: v = 16'h7FFF;
               2: v = 16'h0000;
               default: v = 16'hFFFF;
            endcase
         end
      endcase
      return v;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_len();
      logic [WIDTH-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = -WIDTH'($urandom_range(1, 4000));
         2: v = rnd_val();
         default: v = WIDTH'($urandom_range(1, 2560));
      endcase
      return v;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int first_t;
      int last_t;
      int gap_bad;

      // the reference itself, pinned to hand-computed values
`ifdef RDNORM_ROUND_EN
      check("model_basic_x", 64'(ref_comp(16'h0300, 16'h0500)), 64'h009A);
      check("model_neg_x",   64'(ref_comp(16'hFD00, 16'h0500)), 64'hFF66);
`else
      check("model_basic_x", 64'(ref_comp(16'h0300, 16'h0500)), 64'h0099);
      check("model_neg_x",   64'(ref_comp(16'hFD00, 16'h0500)), 64'hFF67);
`endif
      check("model_sat",  64'(ref_comp(16'h0600, 16'h0500)), 64'h0100);
      check("model_zero", 64'(ref_comp(16'h0005, 16'h0000)), 64'h0000);

      repeat (3) @(negedge clk);
      check("reset_valid", 64'(valid_out), 64'(0));
      check("reset_rd", 64'({RD_out.x, RD_out.y, RD_out.z}), 64'(0));
      check("reset_ovf", 64'(overflow_out), 64'(0));
      check("reset_dz", 64'(div_zero_out), 64'(0));
      chk_en = 1;
      reset  = 1'b0;

`ifdef RDNORM_ROUND_EN
      directed("basic", 16'h0300, 16'h0400, 16'h0000, 16'h0500, {16'h009A, 16'h00CD, 16'h0000}, 1'b0);
      directed("signs", 16'hFD00, 16'h0400, 16'hFC00, 16'h0500, {16'hFF66, 16'h00CD, 16'hFF33}, 1'b0);
`else
      directed("basic", 16'h0300, 16'h0400, 16'h0000, 16'h0500, {16'h0099, 16'h00CC, 16'h0000}, 1'b0);
      directed("signs", 16'hFD00, 16'h0400, 16'hFC00, 16'h0500, {16'hFF67, 16'h00CC, 16'hFF34}, 1'b0);
`endif
      directed("sat",     16'h0600, 16'h0000, 16'h0000, 16'h0500, {16'h0100, 16'h0000, 16'h0000}, 1'b0);
      directed("zerolen", 16'h0005, 16'h0005, 16'h0005, 16'h0000, 48'h0, 1'b1);
      directed("neglen",  16'h0100, 16'h0000, 16'h0000, 16'hFFFF, 48'h0, 1'b1);
      directed("extreme", 16'h8000, 16'h7FFF, 16'h0001, 16'h7FFF, {16'hFF00, 16'h0100, 16'h0000}, 1'b0);

      // reset while the fourth quotient bit is being computed
      @(negedge clk);
      drive(16'h0300, 16'h0400, 16'h0000, 16'h0500);
      @(negedge clk);
      valid_in = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_mid_rd", 64'({RD_out.x, RD_out.y, RD_out.z}), 64'(0));
      check("rst_mid_valid", 64'(valid_out), 64'(0));
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         if (valid_out === 1'b1) pulses++;
      end
      check("rst_mid_no_pulse", 64'(pulses), 64'(0));
`ifdef RDNORM_ROUND_EN
      directed("after_rst", 16'h0300, 16'h0400, 16'h0000, 16'h0500, {16'h009A, 16'h00CD, 16'h0000}, 1'b0);
`else
      directed("after_rst", 16'h0300, 16'h0400, 16'h0000, 16'h0500, {16'h0099, 16'h00CC, 16'h0000}, 1'b0);
`endif

      // burst of six back-to-back packets into a four-entry buffer
      check("burst_ovf_before", 64'(overflow_out), 64'(0));
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive(WIDTH'((k + 1) * 256), WIDTH'(k), -WIDTH'(k * 100), 16'h0700);
      end
      @(negedge clk);
      valid_in = 1'b0;
      check("burst_ovf_set", 64'(overflow_out), 64'(1));
      pulses = 0;
      first_t = 0;
      last_t = 0;
      gap_bad = 0;
      repeat (80) begin
         @(negedge clk);
         if (valid_out === 1'b1) begin
            if (pulses == 0) first_t = cyc;
            else if (cyc - last_t != LAT) gap_bad++;
            last_t = cyc;
            pulses++;
         end
      end
      check("burst_pulses", 64'(pulses), 64'(5));
      check("burst_spacing", 64'(gap_bad), 64'(0));
      check("burst_ovf_sticky", 64'(overflow_out), 64'(1));

      // randomized traffic
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dut_pulses = 0;
      model_accepts = 0;
      for (int n = 0; n < 500; n++) begin
         if ((n / 100) % 2 == 1) valid_in = ($urandom_range(0, 2) != 0);
         else                    valid_in = ($urandom_range(0, 9) == 0);
         RDLEN_in.x   = rnd_val();
         RDLEN_in.y   = rnd_val();
         RDLEN_in.z   = rnd_val();
         RDLEN_in.len = rnd_len();
         @(negedge clk);
      end
      valid_in = 1'b0;
      repeat (80) @(negedge clk);
      check("random_pulse_count", 64'(dut_pulses), 64'(model_accepts));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/direction_normalize.md
Name: direction_normalize

Overview:
- Stage directly downstream of the direction square-root stage; consumes RayDirection_len packets {x, y, z, len}.
- Produces a unit-length RayDirection: each component divided by len, in signed Q-format.
- Uses one shared iterative restoring-division engine: three parallel quotient datapaths driven by one bit counter.
- A small input FIFO absorbs packets, because upstream has no backpressure.

Parameters:
- WIDTH, 16 (package `WIDTH), total bits of each signed fixed-point value.
- Q_BITS, 8 (package `Q_BITS), fractional bits.
- FIFO_DEPTH, 4, input buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  RDLEN_in is valid this cycle.
- RDLEN_in  in  RayDirection_len  {x, y, z, len}, each WIDTH signed.
- RD_out  out  RayDirection  normalized {x, y, z}, Q-format.
- valid_out  out  1  one-cycle pulse; RD_out is valid.
- div_zero_out  out  1  pulses with valid_out when len<=0.
- overflow_out  out  1  sticky: an input was dropped.

Behaviour:
- Reset values: RD_out=0, valid_out=0, div_zero_out=0, overflow_out=0; FIFO emptied; FSM in IDLE.
- Reset mid-division abandons the packet; no valid_out is produced for it.
- FIFO write rules:
  - Write on valid_in.
  - valid_in while full and no pop in that cycle: packet dropped, overflow_out set (stays set until reset).
  - Simultaneous pop and write while full: write accepted.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE, FIFO non-empty: pop on this edge and register the operands:
  - signs sx/sy/sz;
  - magnitudes |x|,|y|,|z| (unsigned WIDTH bits; the most negative value is handled);
  - len;
  - K-bit counter (K=Q_BITS).
  - Go to DIVIDE.
- Per component, at load time:
  - If len<=0: flag zero, result 0.
  - Else if |c|>=len: result saturates to 1.0 (2^Q_BITS); the divider is bypassed for that component.
  - Else remainder r=|c|, WIDTH+1 bits.
- DIVIDE, one edge per quotient bit, MSB first:
  - r=r<<1;
  - if r>=len then r=r-len and the quotient bit is 1, else the bit is 0.
  - After K edges, go to DONE.
- DONE (one cycle):
  - Apply sign: a negative component gives the two's-complement negation.
  - Register RD_out and pulse valid_out; pulse div_zero_out if flagged.
  - Return to IDLE; a new pop may occur on the next IDLE cycle.
- Latency:
  - With the FIFO empty and the FSM idle, valid_out rises K+2 edges after the edge that sampled valid_in (10 with the defaults).
  - Throughput: one packet per K+2 cycles.
- RD_out holds its value between pulses.
- Result = floor(|c|*2^Q_BITS/len), truncated toward zero in magnitude.
- Component magnitude is at most 2^Q_BITS, which requires WIDTH>=Q_BITS+2.

Optional Feature:
- Macro RDNORM_ROUND_EN.
- Defined:
  - K=Q_BITS+1; the extra LSB quotient bit is added to the magnitude (round half up), then dropped.
  - Result magnitude is clamped to 2^Q_BITS.
  - Latency becomes Q_BITS+3 edges.
- Undefined: truncation as above; K=Q_BITS.

Decomposition:
- Shared package:
  - typedefs RayDirection and RayDirection_len;
  - WIDTH and Q_BITS;
  - FSM state enum norm_state_t.
- Sub-module rdlen_fifo: synchronous FIFO of RayDirection_len with push, pop, full, empty and overflow outputs.
- Divider datapath stays inline; the three components are instances of a generate loop.

Test Plan:
- Basic vector: {x=0x0300 (3.0), y=0x0400 (4.0), z=0, len=0x0500} ->
  - RD_out={0x0099, 0x00CC, 0x0000};
  - valid_out high exactly 10 edges after valid_in.
  - With RDNORM_ROUND_EN: {0x009A, 0x00CD, 0}, 11 edges.
- Signs: {x=0xFD00 (-3.0), y=0x0400, z=0xFC00, len=0x0500} -> {0xFF67, 0x00CC, 0xFF34}.
- Saturation and zero length:
  - {x=0x0600, y=0, z=0, len=0x0500} -> x=0x0100.
  - {x=5, y=5, z=5, len=0} -> RD_out=0, div_zero_out pulses with valid_out.
- Burst: valid_in held for 6 consecutive cycles, FIFO_DEPTH=4 ->
  - overflow_out sets on the first dropped packet and stays set;
  - accepted packets emerge in order, each 10 cycles apart.
- Reset: reset asserted at DIVIDE cycle 4 ->
  - no valid_out afterwards, all outputs 0;
  - a new packet after reset produces the correct result at the normal latency.
